// File: rtl/tok_pkg.sv
// Shared token encodings, matcher states and keyword constants for keyword_tokenizer.
package tok_pkg;

  typedef enum logic [1:0] {
    TOK_WORD  = 2'd0,
    TOK_BEGIN = 2'd1,
    TOK_END   = 2'd2,
    TOK_EOS   = 2'd3
  } tok_type_e;

  typedef enum logic [1:0] {
    ST_GAP   = 2'd0,
    ST_MATCH = 2'd1,
    ST_OTHER = 2'd2
  } match_state_e;

  localparam logic [7:0]  CHAR_SPACE = 8'h20;
  localparam logic [39:0] KW_BEGIN   = 40'h62_65_67_69_6e;
  localparam logic [23:0] KW_END     = 24'h65_6e_64;

  // Character at position i_idx of the selected keyword (0 = "begin", 1 = "end").
  function automatic logic [7:0] kw_char(input logic i_is_end, input logic [2:0] i_idx);
    logic [39:0] w_kw;
    w_kw = i_is_end ? {KW_END, 16'h0000} : KW_BEGIN;
    case (i_idx)
      3'd0:    kw_char = w_kw[39:32];
      3'd1:    kw_char = w_kw[31:24];
      3'd2:    kw_char = w_kw[23:16];
      3'd3:    kw_char = w_kw[15:8];
      3'd4:    kw_char = w_kw[7:0];
      default: kw_char = 8'h00;
    endcase
  endfunction

  function automatic logic [2:0] kw_len(input logic i_is_end);
    kw_len = i_is_end ? 3'd3 : 3'd5;
  endfunction

endpackage

// File: rtl/tok_fifo2.sv
// Two-entry shift FIFO for tokens; accepts up to two pushes per cycle, head is always entry 0.
module tok_fifo2
  import tok_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push0,
  input  tok_type_e        i_type0,
  input  logic [LEN_W-1:0] i_len0,
  input  logic             i_push1,
  input  tok_type_e        i_type1,
  input  logic [LEN_W-1:0] i_len1,
  input  logic             i_pop,
  output logic             o_valid,
  output tok_type_e        o_type,
  output logic [LEN_W-1:0] o_len,
  output logic             o_empty
);

  logic [1:0]       r_count;
  logic             r_valid;
  logic             r_empty;
  tok_type_e        r_type0;
  tok_type_e        r_type1;
  logic [LEN_W-1:0] r_len0;
  logic [LEN_W-1:0] r_len1;

  logic [1:0]       w_count_nxt;
  tok_type_e        w_type0_nxt;
  tok_type_e        w_type1_nxt;
  logic [LEN_W-1:0] w_len0_nxt;
  logic [LEN_W-1:0] w_len1_nxt;
  logic             w_pop;

  assign w_pop = r_valid & i_pop;

  // Pop shifts entry 1 forward first; pushes then land at the first free slot.
  always_comb begin
    w_type0_nxt = r_type0;
    w_len0_nxt  = r_len0;
    w_type1_nxt = r_type1;
    w_len1_nxt  = r_len1;
    w_count_nxt = r_count;
    if (w_pop) begin
      w_type0_nxt = r_type1;
      w_len0_nxt  = r_len1;
      w_count_nxt = r_count - 2'd1;
    end else begin
      w_count_nxt = r_count;
    end
    if (i_push0) begin
      case (w_count_nxt)
        2'd0: begin
          w_type0_nxt = i_type0;
          w_len0_nxt  = i_len0;
          if (i_push1) begin
            w_type1_nxt = i_type1;
            w_len1_nxt  = i_len1;
            w_count_nxt = 2'd2;
          end else begin
            w_count_nxt = 2'd1;
          end
        end
        2'd1: begin
          w_type1_nxt = i_type0;
          w_len1_nxt  = i_len0;
          w_count_nxt = 2'd2;
        end
        default: begin
          w_count_nxt = 2'd2;
        end
      endcase
    end else begin
      w_type1_nxt = w_type1_nxt;
    end
  end

  // Status flags are registered from the next count so no path runs from i_pop to outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 2'd0;
      r_valid <= 1'b0;
      r_empty <= 1'b1;
      r_type0 <= TOK_WORD;
      r_type1 <= TOK_WORD;
      r_len0  <= '0;
      r_len1  <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != 2'd0);
      r_empty <= (w_count_nxt == 2'd0);
      r_type0 <= w_type0_nxt;
      r_type1 <= w_type1_nxt;
      r_len0  <= w_len0_nxt;
      r_len1  <= w_len1_nxt;
    end
  end

  assign o_valid = r_valid;
  assign o_type  = r_type0;
  assign o_len   = r_len0;
  assign o_empty = r_empty;

endmodule

// File: rtl/keyword_tokenizer.sv
// Splits a space-delimited byte stream into WORD/BEGIN/END/EOS tokens.
// Define CASE_FOLD_EN to fold 'A'-'Z' to lowercase before keyword matching.
module keyword_tokenizer
  import tok_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             tok_valid,
  output logic [1:0]       tok_type,
  output logic [LEN_W-1:0] tok_len,
  input  logic             tok_ready
);

  match_state_e     r_state;
  logic [2:0]       r_idx;
  logic             r_kw_end;
  logic [LEN_W-1:0] r_len;

  match_state_e     w_state_nxt;
  logic [2:0]       w_idx_nxt;
  logic             w_kw_end_nxt;
  logic [LEN_W-1:0] w_len_nxt;
  match_state_e     w_cur_state;
  logic [2:0]       w_cur_idx;
  logic             w_cur_kw;
  logic [LEN_W-1:0] w_cur_len;
  logic [7:0]       w_char;
  logic             w_accept;
  logic             w_is_space;
  logic             w_len_sat;
  logic             w_word_pending;
  tok_type_e        w_word_type;
  logic             w_push0;
  logic             w_push1;
  tok_type_e        w_type0;
  tok_type_e        w_type1;
  logic [LEN_W-1:0] w_len0;
  logic [LEN_W-1:0] w_len1;
  logic             w_in_ready;
  tok_type_e        w_fifo_type;

`ifdef CASE_FOLD_EN
  assign w_char = ((in_data >= 8'h41) && (in_data <= 8'h5a)) ? (in_data | 8'h20) : in_data;
`else
  assign w_char = in_data;
`endif

  assign w_accept   = in_valid & w_in_ready;
  assign w_is_space = (w_char == CHAR_SPACE);
  assign w_len_sat  = &r_len;

  // w_cur_* is the word as it stands after this character; it drives both the
  // next state and the type/length of any token emitted this cycle.
  always_comb begin
    w_cur_state    = r_state;
    w_cur_idx      = r_idx;
    w_cur_kw       = r_kw_end;
    w_cur_len      = r_len;
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_kw_end_nxt   = r_kw_end;
    w_len_nxt      = r_len;
    w_push0        = 1'b0;
    w_push1        = 1'b0;
    w_type0        = TOK_WORD;
    w_type1        = TOK_EOS;
    w_len0         = '0;
    w_len1         = '0;
    w_word_pending = 1'b0;
    w_word_type    = TOK_WORD;

    if (!w_is_space) begin
      w_cur_len = w_len_sat ? r_len : (r_len + LEN_W'(1));
      case (r_state)
        ST_GAP: begin
          if (w_char == kw_char(1'b0, 3'd0)) begin
            w_cur_state = ST_MATCH;
            w_cur_kw    = 1'b0;
            w_cur_idx   = 3'd1;
          end else if (w_char == kw_char(1'b1, 3'd0)) begin
            w_cur_state = ST_MATCH;
            w_cur_kw    = 1'b1;
            w_cur_idx   = 3'd1;
          end else begin
            w_cur_state = ST_OTHER;
            w_cur_idx   = 3'd0;
          end
        end
        ST_MATCH: begin
          // A saturating length also demotes the word, so keywords never carry a clipped count.
          if (!w_len_sat && (r_idx < kw_len(r_kw_end)) && (w_char == kw_char(r_kw_end, r_idx))) begin
            w_cur_idx = r_idx + 3'd1;
          end else begin
            w_cur_state = ST_OTHER;
          end
        end
        default: begin
          w_cur_state = ST_OTHER;
        end
      endcase
    end else begin
      w_cur_len = r_len;
    end

    w_word_pending = w_is_space ? (r_state != ST_GAP) : 1'b1;
    if ((w_cur_state == ST_MATCH) && (w_cur_idx == kw_len(w_cur_kw))) begin
      w_word_type = w_cur_kw ? TOK_END : TOK_BEGIN;
    end else begin
      w_word_type = TOK_WORD;
    end

    if (w_accept) begin
      if (in_last || w_is_space) begin
        w_state_nxt  = ST_GAP;
        w_idx_nxt    = 3'd0;
        w_kw_end_nxt = 1'b0;
        w_len_nxt    = '0;
        if (w_word_pending) begin
          w_push0 = 1'b1;
          w_type0 = w_word_type;
          w_len0  = w_cur_len;
          w_push1 = in_last;
        end else begin
          w_push0 = in_last;
          w_type0 = TOK_EOS;
        end
      end else begin
        w_state_nxt  = w_cur_state;
        w_idx_nxt    = w_cur_idx;
        w_kw_end_nxt = w_cur_kw;
        w_len_nxt    = w_cur_len;
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Matcher state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_GAP;
      r_idx    <= 3'd0;
      r_kw_end <= 1'b0;
      r_len    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_kw_end <= w_kw_end_nxt;
      r_len    <= w_len_nxt;
    end
  end

  tok_fifo2 #(.LEN_W(LEN_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push0 (w_push0),
    .i_type0 (w_type0),
    .i_len0  (w_len0),
    .i_push1 (w_push1),
    .i_type1 (w_type1),
    .i_len1  (w_len1),
    .i_pop   (tok_ready),
    .o_valid (tok_valid),
    .o_type  (w_fifo_type),
    .o_len   (tok_len),
    .o_empty (w_in_ready)
  );

  assign tok_type = w_fifo_type;
  assign in_ready = w_in_ready;

endmodule

// File: tb/tb_keyword_tokenizer.sv
// Self-checking bench for keyword_tokenizer: string-level token model plus directed literal checks.
module tb_keyword_tokenizer;

  localparam int LEN_W  = 8;
  localparam int MAXLEN = 255;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_last = 1'b0;
  logic             tok_ready = 1'b0;
  logic             in_ready;
  logic             tok_valid;
  logic [1:0]       tok_type;
  logic [LEN_W-1:0] tok_len;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] exp_q[$];
  logic [9:0] dut_log[$];
  string      m_word = "";
  int         m_cnt = 0;
  bit         m_acc = 1'b0;
  logic [7:0] m_c;

  always #5 clk = ~clk;

  keyword_tokenizer #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .tok_valid (tok_valid),
    .tok_type  (tok_type),
    .tok_len   (tok_len),
    .tok_ready (tok_ready)
  );

  function automatic logic [9:0] word_tok(input string w, input int cnt);
    logic [1:0] t;
    logic [7:0] l;
    t = 2'd0;
    if (cnt <= MAXLEN && w == "begin") t = 2'd1;
    else if (cnt <= MAXLEN && w == "end") t = 2'd2;
    l = (cnt > MAXLEN) ? 8'(MAXLEN) : 8'(cnt);
    return {t, l};
  endfunction

  // Behavioural model: the queue of tokens the DUT must be holding.
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      exp_q.delete();
      m_word = "";
      m_cnt  = 0;
      m_acc  = 1'b0;
    end else begin
      m_acc = 1'b0;
      if (tok_valid && tok_ready) dut_log.push_back({tok_type, tok_len});
      if (tok_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end else if (in_valid && exp_q.size() == 0) begin
        m_acc = 1'b1;
        m_c = in_data;
`ifdef CASE_FOLD_EN
        if (m_c >= 8'h41 && m_c <= 8'h5a) m_c = m_c + 8'h20;
`endif
        if (m_c != 8'h20) begin
          m_cnt++;
          if (m_cnt <= 6) m_word = $sformatf("%s%c", m_word, m_c);
        end
        if (m_c == 8'h20 || in_last) begin
          if (m_cnt > 0) exp_q.push_back(word_tok(m_word, m_cnt));
          if (in_last) exp_q.push_back({2'd3, 8'd0});
          m_word = "";
          m_cnt  = 0;
        end
      end
    end
  end

  // Per-cycle compare against the model, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    n_cmp++;
    if (tok_valid !== (exp_q.size() != 0)) begin
      n_err++;
      $display("FAIL tok_valid t=%0t got %b want %b", $time, tok_valid, exp_q.size() != 0);
    end
    n_cmp++;
    if (in_ready !== (exp_q.size() == 0)) begin
      n_err++;
      $display("FAIL in_ready t=%0t got %b want %b", $time, in_ready, exp_q.size() == 0);
    end
    if (exp_q.size() != 0 && tok_valid === 1'b1) begin
      n_cmp++;
      if ({tok_type, tok_len} !== exp_q[0]) begin
        n_err++;
        $display("FAIL tok_head t=%0t got type %0d len %0d want type %0d len %0d",
                 $time, tok_type, tok_len, exp_q[0][9:8], exp_q[0][7:0]);
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic expect_count(input string nm, input int n);
    n_cmp++;
    if (dut_log.size() != n) begin
      n_err++;
      $display("FAIL %s token count got %0d want %0d", nm, dut_log.size(), n);
    end
  endtask

  task automatic expect_log(input string nm, input int idx, input logic [9:0] want);
    if (idx < dut_log.size()) begin
      chk(nm, {6'd0, dut_log[idx]}, {6'd0, want});
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL %s token %0d missing want %h", nm, idx, want);
    end
  endtask

  task automatic send(input logic [7:0] c, input bit last);
    bit done;
    done = 1'b0;
    in_data  = c;
    in_last  = last;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (m_acc) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout char %h", c);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last);
    for (int i = 0; i < s.len(); i++) send(s[i], last && (i == s.len() - 1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] want_kw;
    tok_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {4'd0, tok_valid, in_ready, tok_type, tok_len}, {4'd0, 1'b0, 1'b1, 2'd0, 8'd0});
    @(posedge clk);
    #1 reset = 1'b1;
    idle(2);

    dut_log.delete();
    send_str("begin end ", 1'b0);
    idle(4);
    expect_count("begin_end", 2);
    expect_log("begin_end_0", 0, {2'd1, 8'd5});
    expect_log("begin_end_1", 1, {2'd2, 8'd3});

    dut_log.delete();
    send_str("  x   ", 1'b0);
    idle(4);
    expect_count("spaces_x", 1);
    expect_log("spaces_x_0", 0, {2'd0, 8'd1});

    dut_log.delete();
    tok_ready = 1'b0;
    send_str("ben", 1'b1);
    idle(5);
    chk("ben_hold", {4'd0, tok_valid, in_ready, tok_type, tok_len}, {4'd0, 1'b1, 1'b0, 2'd0, 8'd3});
    tok_ready = 1'b1;
    idle(4);
    expect_count("ben_last", 2);
    expect_log("ben_last_0", 0, {2'd0, 8'd3});
    expect_log("ben_last_1", 1, {2'd3, 8'd0});

`ifdef CASE_FOLD_EN
    want_kw = {2'd2, 8'd3};
`else
    want_kw = {2'd0, 8'd3};
`endif
    dut_log.delete();
    send_str("END ", 1'b0);
    idle(4);
    expect_log("upper_end", 0, want_kw);

`ifdef CASE_FOLD_EN
    want_kw = {2'd1, 8'd5};
`else
    want_kw = {2'd0, 8'd5};
`endif
    dut_log.delete();
    send_str("BeGiN ", 1'b0);
    idle(4);
    expect_log("mixed_begin", 0, want_kw);

    dut_log.delete();
    send_str("beginx en ben e b end begin ", 1'b0);
    idle(4);
    expect_count("near_miss", 7);
    expect_log("near_miss_beginx", 0, {2'd0, 8'd6});
    expect_log("near_miss_en", 1, {2'd0, 8'd2});
    expect_log("near_miss_ben", 2, {2'd0, 8'd3});
    expect_log("near_miss_e", 3, {2'd0, 8'd1});
    expect_log("near_miss_b", 4, {2'd0, 8'd1});
    expect_log("near_miss_end", 5, {2'd2, 8'd3});
    expect_log("near_miss_begin", 6, {2'd1, 8'd5});

    dut_log.delete();
    for (int i = 0; i < 300; i++) send(8'h61, 1'b0);
    send(8'h20, 1'b0);
    idle(4);
    expect_count("long_word", 1);
    expect_log("long_word_sat", 0, {2'd0, 8'd255});

    dut_log.delete();
    send_str("end ", 1'b1);
    idle(4);
    send(8'h20, 1'b1);
    idle(4);
    expect_count("last_on_space", 3);
    expect_log("last_on_space_end", 0, {2'd2, 8'd3});
    expect_log("last_on_space_eos", 1, {2'd3, 8'd0});
    expect_log("lone_last_eos", 2, {2'd3, 8'd0});

    dut_log.delete();
    tok_ready = 1'b0;
    send_str("end ", 1'b0);
    idle(6);
    chk("stall_hold", {4'd0, tok_valid, in_ready, tok_type, tok_len}, {4'd0, 1'b1, 1'b0, 2'd2, 8'd3});
    reset = 1'b0;
    #2;
    chk("reset_queued", {14'd0, tok_valid, in_ready}, {14'd0, 1'b0, 1'b1});
    @(posedge clk);
    #1 reset = 1'b1;
    send_str("beg", 1'b0);
    reset = 1'b0;
    #2;
    chk("reset_midword", {14'd0, tok_valid, in_ready}, {14'd0, 1'b0, 1'b1});
    @(posedge clk);
    #1 reset = 1'b1;
    tok_ready = 1'b1;
    send(8'h20, 1'b0);
    idle(5);
    expect_count("after_reset", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keyword_tokenizer.md
KEYWORD_TOKENIZER -- requirements
Module: keyword_tokenizer

Interface
REQ-001 The module SHALL have parameter LEN_W, default 8, giving the width of the token length field.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit: in_data and in_last are valid this cycle.
REQ-005 The module SHALL have port in_data, input, 8 bits: ASCII character.
REQ-006 The module SHALL have port in_last, input, 1 bit: this character ends the stream.
REQ-007 The module SHALL have port in_ready, output, 1 bit: a character is accepted when in_valid and in_ready are both high.
REQ-008 The module SHALL have port tok_valid, output, 1 bit: the FIFO head token is valid.
REQ-009 The module SHALL have port tok_type, output, 2 bits: 0 WORD, 1 BEGIN, 2 END, 3 EOS.
REQ-010 The module SHALL have port tok_len, output, LEN_W bits: number of characters in the token's word.
REQ-011 The module SHALL have port tok_ready, input, 1 bit: the FIFO head is popped when tok_valid and tok_ready are both high.

Function
REQ-012 The block SHALL treat 8'h20 as the only delimiter and SHALL treat every other byte as a word character.
REQ-013 The matcher FSM SHALL have states GAP (between words), MATCH (prefix still equal to "begin" or "end", with a match index) and OTHER (prefix matches neither).
REQ-014 The FSM SHALL make these transitions on each accepted character:
- GAP, non-space -> MATCH if the character is 'b' or 'e', else OTHER.
- MATCH, non-space -> stay in MATCH while the prefix still matches, else OTHER.
- MATCH or OTHER, space -> GAP and emit one token.
- GAP, space -> GAP with no token (no empty tokens).
REQ-015 On emission, tok_type SHALL be BEGIN if the word is exactly "begin", END if it is exactly "end", else WORD; "beginx", "ben" and "en" are WORD.
REQ-016 tok_len SHALL equal the character count of the emitted word and SHALL saturate at 2^LEN_W-1; a saturated word is WORD.
REQ-017 An accepted character with in_last high SHALL first complete any pending word (including that character if non-space), SHALL then emit one EOS token with tok_len 0, and the FSM SHALL return to GAP.
REQ-018 Tokens SHALL be written into a 2-entry FIFO and SHALL appear on tok_valid on the cycle after the accepting edge (latency 1).
REQ-019 When one accepted character produces both a word token and EOS, the word token SHALL be enqueued ahead of EOS.
REQ-020 in_ready SHALL be high exactly when the FIFO is empty; it SHALL be a registered count compare with no combinational path from tok_ready.
REQ-021 A push and a pop in the same cycle SHALL both take effect; the FIFO SHALL never overflow and SHALL never present invalid data.
REQ-022 tok_type and tok_len SHALL hold stable while tok_valid is high and tok_ready is low.

Reset
REQ-023 While reset is low, the FSM SHALL be GAP, the match index and length counter SHALL be 0, the FIFO SHALL be empty, and outputs SHALL be tok_valid=0, tok_type=0, tok_len=0, in_ready=1.
REQ-024 Reset asserted mid-word or with tokens queued SHALL discard all partial and queued state with no token emitted.

Configuration
REQ-025 With CASE_FOLD_EN defined, bytes 'A'-'Z' SHALL be folded to lowercase before matching, so "BeGiN" yields BEGIN; the length count SHALL be unaffected.
REQ-026 With CASE_FOLD_EN undefined, matching SHALL be exact lowercase only, so "Begin" yields WORD.

Structure
REQ-027 Package tok_pkg SHALL hold the token type encodings, CHAR_SPACE, and the keyword byte constants "begin" and "end".
REQ-028 The 2-entry FIFO SHALL be sub-module tok_fifo2; the matcher FSM SHALL live in keyword_tokenizer.

Verification
REQ-029 Stream "begin end " with tok_ready=1 -> tokens BEGIN/5 then END/3, each 1 cycle after its space is accepted.
REQ-030 Stream "  x   " -> exactly one token WORD/1.
REQ-031 Stream "ben" with in_last on 'n' -> WORD/3 then EOS/0, in that order; in_ready=0 until both are popped.
REQ-032 Stream "END " -> END/3 with CASE_FOLD_EN defined, WORD/3 without.
REQ-033 A 300-char non-space word then a space, with LEN_W=8 -> WORD/255.
REQ-034 Hold tok_ready=0 after "end " -> tok_valid holds END/3 and in_ready stays 0; assert reset mid-word -> tok_valid=0, in_ready=1, and no token appears afterwards.
